// File: rtl/mpu_i2c_pkg.sv
// Shared constants for the MPU_6050-style I2C target: one-hot FSM encoding and register map.
package mpu_i2c_pkg;

    localparam int ST_SZ = 10;

    localparam logic [6:0] MPU_6050   = 7'h68;
    localparam logic [7:0] WHO_AM_I   = 8'h75;
    localparam logic [7:0] PWR_MGMT_1 = 8'h6B;

    typedef enum logic [ST_SZ-1:0] {
        IDLE   = 10'b00_0000_0001,
        ADDR   = 10'b00_0000_0010,
        ACK_A  = 10'b00_0000_0100,
        PTR    = 10'b00_0000_1000,
        ACK_P  = 10'b00_0001_0000,
        WR     = 10'b00_0010_0000,
        ACK_W  = 10'b00_0100_0000,
        RD     = 10'b00_1000_0000,
        MACK   = 10'b01_0000_0000,
        WAIT_P = 10'b10_0000_0000
    } state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes the SCL/SDA pads and decodes SCL edges plus START/STOP from the synced values.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic CLK,
    input  logic RST_n,
    input  logic scl_pad,
    input  logic sda_pad,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sh, sda_sh;
    logic                   scl, scl_h, sda_h;

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            scl_sh <= '1;
            sda_sh <= '1;
            scl_h  <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_sh <= {scl_sh[SYNC_STAGES-2:0], scl_pad};
            sda_sh <= {sda_sh[SYNC_STAGES-2:0], sda_pad};
            scl_h  <= scl;
            sda_h  <= sda;
        end
    end

    assign scl      = scl_sh[SYNC_STAGES-1];
    assign sda      = sda_sh[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_h;
    assign scl_fall = ~scl & scl_h;
    assign start    = scl & scl_h & sda_h & ~sda;
    assign stop     = scl & scl_h & ~sda_h & sda;

endmodule

// File: rtl/mpu_i2c_target.sv
// I2C target: address match, register pointer, auto-incrementing writes/reads to an external bank.
module mpu_i2c_target
    import mpu_i2c_pkg::*;
#(
    parameter logic [6:0] SLV_ADDR    = MPU_6050,
    parameter int         DATA_I2C_SZ = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                   CLK,
    input  logic                   RST_n,
    input  logic                   I_SCL,
    input  logic                   I_SDA,
    output logic                   O_SDA_OE,
    output logic [7:0]             O_REG_ADDR,
    output logic [DATA_I2C_SZ-1:0] O_REG_WDATA,
    output logic                   O_REG_WE,
    output logic                   O_REG_RD,
    input  logic [DATA_I2C_SZ-1:0] I_REG_RDATA,
    output logic                   O_BUSY,
    output logic                   O_ERR
);

    localparam int DW = DATA_I2C_SZ;
    localparam int CW = $clog2(DW);

    state_t          state, nxt;
    logic            sda, scl_rise, scl_fall, start, stop;
    logic [DW-1:0]   sh, sh_in;
    logic [DW-2:0]   tx;
    logic [CW-1:0]   cnt;
    logic [7:0]      ptr;
    logic            bit_seen, bit_end, last, addr_hit, in_byte, nack, rd_d, restart;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .scl_pad  (I_SCL),
        .sda_pad  (I_SDA),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // A bit counts only once both its rising and falling SCL edge were seen, so the
    // rising edge that precedes a repeated START never looks like a partial byte.
    assign bit_end  = scl_fall & bit_seen;
    assign last     = (cnt == CW'(DW-1));
    assign sh_in    = {sh[DW-2:0], sda};
    assign addr_hit = (sh[DW-1:1] == SLV_ADDR) && (sh[DW-1:1] != 7'h00);
    assign in_byte  = state inside {ADDR, PTR, WR, RD};
    assign restart  = (nxt != state) | start | stop;
    assign O_REG_ADDR = ptr;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (start)     nxt = ADDR;
        else if (stop) nxt = IDLE;
        else if (bit_end) begin
            case (state)
                ADDR:    if (last) nxt = addr_hit ? ACK_A : IDLE;
                ACK_A:   nxt = sh[0] ? RD : PTR;
                PTR:     if (last) nxt = ACK_P;
                ACK_P:   nxt = WR;
                WR:      if (last) nxt = ACK_W;
                ACK_W:   nxt = WR;
                RD:      if (last) nxt = MACK;
                MACK:    nxt = nack ? WAIT_P : RD;
                default: nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sh          <= '0;
            tx          <= '0;
            cnt         <= '0;
            ptr         <= 8'h00;
            bit_seen    <= 1'b0;
            nack        <= 1'b0;
            rd_d        <= 1'b0;
            O_SDA_OE    <= 1'b0;
            O_REG_WDATA <= '0;
            O_REG_WE    <= 1'b0;
            O_REG_RD    <= 1'b0;
            O_BUSY      <= 1'b0;
            O_ERR       <= 1'b0;
        end else begin
            O_REG_WE <= 1'b0;
            O_REG_RD <= 1'b0;
            rd_d     <= O_REG_RD;

            if (restart) begin
                cnt      <= '0;
                bit_seen <= 1'b0;
            end else if (scl_rise) begin
                bit_seen <= 1'b1;
            end else if (bit_end && in_byte) begin
                cnt      <= cnt + 1'b1;
                bit_seen <= 1'b0;
            end

            if (scl_rise && (state inside {ADDR, PTR, WR})) sh <= sh_in;
            if (scl_rise && state == PTR && last) ptr <= sh_in;
            if (scl_rise && state == WR && last) begin
                O_REG_WDATA <= sh_in;
                O_REG_WE    <= 1'b1;
            end
            if (scl_rise && state == MACK) begin
                nack <= sda;
                if (!sda) ptr <= ptr + 8'h01;
            end
            // Increment after the WE cycle so the strobe sees the pointer it was meant for.
            if (state == WR && nxt == ACK_W) ptr <= ptr + 8'h01;

            if (restart) begin
                O_SDA_OE <= (nxt inside {ACK_A, ACK_P, ACK_W}) && !(start || stop);
                if (nxt == RD && !(start || stop)) O_REG_RD <= 1'b1;
            end else if (state == RD) begin
                if (rd_d) begin
                    tx       <= I_REG_RDATA[DW-2:0];
                    O_SDA_OE <= ~I_REG_RDATA[DW-1];
                end else if (bit_end) begin
                    tx       <= {tx[DW-3:0], 1'b0};
                    O_SDA_OE <= ~tx[DW-2];
                end
            end

            if ((start || stop) && in_byte && cnt != '0) O_ERR <= 1'b1;
            else if (state == ADDR && nxt == ACK_A)      O_ERR <= 1'b0;

            if (start || stop)                      O_BUSY <= 1'b0;
            else if (state == ADDR && nxt == ACK_A) O_BUSY <= 1'b1;
        end
    end

endmodule
